// File: rtl/bmp_trim_pkg.sv
// Shared types and sizing helpers for the bitmap bounding-box scanner.
package bmp_trim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int unsigned DEF_COLS = 24;
  localparam int unsigned DEF_ROWS = 64;

  // Bits needed to hold any value 0..n inclusive (pads and counts reach n itself).
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bmp_trim_scan_lzc.sv
// Combinational leading-zero counter; an all-zero vector reports W.
module lzc
  import bmp_trim_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]         vec_i,
  output logic [cnt_w(W)-1:0]  zeros_o
);

  localparam int unsigned OW = cnt_w(W);

  // NOTE: the output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    zeros_o = OW'(W);
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) zeros_o = OW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/bmp_trim_scan.sv
// Bounding-box scanner: snapshots a ROWS x COLS bitmap, scans one row per cycle,
// reports the four empty margins. Optional set-pixel count via BMP_TRIM_POPCNT_EN.
module bmp_trim_scan
  import bmp_trim_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ROWS*COLS-1:0]          bitmap,
  output logic                          busy,
  output logic                          done,
  output logic [cnt_w(ROWS)-1:0]        top_pad,
  output logic [cnt_w(ROWS)-1:0]        bottom_pad,
  output logic [cnt_w(COLS)-1:0]        left_pad,
  output logic [cnt_w(COLS)-1:0]        right_pad,
  output logic                          empty,
  output logic [cnt_w(ROWS*COLS)-1:0]   pix_count
);

  localparam int unsigned PW = cnt_w(ROWS);
  localparam int unsigned LW = cnt_w(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned NB = ROWS * COLS;

  state_e          state_q;
  logic [NB-1:0]   shadow_q;
  logic [RW-1:0]   row_idx_q;
  logic [COLS-1:0] col_mask_q;
  logic            hit_q;
  logic [RW-1:0]   first_hit_q;
  logic [RW-1:0]   last_hit_q;

  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   top_q;
  logic [PW-1:0]   bottom_q;
  logic [LW-1:0]   left_q;
  logic [LW-1:0]   right_q;
  logic            empty_q;

  logic [COLS-1:0] row_d;
  logic [COLS-1:0] col_mask_rev_d;
  logic [LW-1:0]   lead_zeros_d;
  logic [LW-1:0]   trail_zeros_d;

  // The row under scan is always the top slice; the shadow shifts up one row per cycle.
  assign row_d = shadow_q[NB-1 -: COLS];

  // NOTE: the shadow holds no reset; every scan reloads it before any row is read.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      shadow_q <= bitmap;
    end else if (state_q == SCAN) begin
      shadow_q <= shadow_q << COLS;
    end
  end

  always_comb begin
    col_mask_rev_d = '0;
    for (int i = 0; i < COLS; i++) col_mask_rev_d[i] = col_mask_q[COLS-1-i];
  end

  lzc #(.W(COLS)) u_lead  (.vec_i(col_mask_q),     .zeros_o(lead_zeros_d));
  lzc #(.W(COLS)) u_trail (.vec_i(col_mask_rev_d), .zeros_o(trail_zeros_d));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_idx_q   <= '0;
      col_mask_q  <= '0;
      hit_q       <= 1'b0;
      first_hit_q <= '0;
      last_hit_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      top_q       <= '0;
      bottom_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      empty_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            row_idx_q   <= '0;
            col_mask_q  <= '0;
            hit_q       <= 1'b0;
            first_hit_q <= '0;
            last_hit_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          col_mask_q <= col_mask_q | row_d;
          if (|row_d) begin
            if (!hit_q) first_hit_q <= row_idx_q;
            last_hit_q <= row_idx_q;
            hit_q      <= 1'b1;
          end
          if (row_idx_q == RW'(ROWS - 1)) begin
            state_q <= FIN;
          end else begin
            row_idx_q <= row_idx_q + 1'b1;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          empty_q <= !hit_q;
          if (hit_q) begin
            top_q    <= PW'(first_hit_q);
            bottom_q <= PW'(ROWS - 1) - PW'(last_hit_q);
          end else begin
            top_q    <= PW'(ROWS);
            bottom_q <= PW'(ROWS);
          end
          // An all-zero column mask makes both counters report COLS on their own.
          left_q  <= lead_zeros_d;
          right_q <= trail_zeros_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign top_pad    = top_q;
  assign bottom_pad = bottom_q;
  assign left_pad   = left_q;
  assign right_pad  = right_q;
  assign empty      = empty_q;

`ifdef BMP_TRIM_POPCNT_EN
  localparam int unsigned CW = cnt_w(NB);

  logic [CW-1:0] row_pop_d;
  logic [CW-1:0] acc_q;
  logic [CW-1:0] pix_q;

  always_comb begin
    row_pop_d = '0;
    for (int i = 0; i < COLS; i++) row_pop_d = row_pop_d + CW'(row_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      pix_q <= '0;
    end else if (state_q == IDLE && start) begin
      acc_q <= '0;
    end else if (state_q == SCAN) begin
      acc_q <= acc_q + row_pop_d;
    end else if (state_q == FIN) begin
      pix_q <= acc_q;
    end
  end

  assign pix_count = pix_q;
`else
  assign pix_count = '0;
`endif

endmodule

// File: tb/tb_bmp_trim_scan.sv
// Self-checking bench for bmp_trim_scan: a row-walking reference model plus directed literals.
module tb_bmp_trim_scan;

  localparam int ROWS = 64;
  localparam int COLS = 24;
  localparam int NB   = ROWS * COLS;
  localparam int SR   = 4;
  localparam int SC   = 8;
`ifdef BMP_TRIM_POPCNT_EN
  localparam int POPCNT_ON = 1;
`else
  localparam int POPCNT_ON = 0;
`endif

  typedef struct {
    int top;
    int bottom;
    int left;
    int right;
    int empty;
    int pix;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic          start_b = 1'b0;
  logic [NB-1:0] bitmap_b = '0;
  logic          busy_b, done_b, empty_b;
  logic [6:0]    top_b, bottom_b;
  logic [4:0]    left_b, right_b;
  logic [10:0]   pix_b;

  // Small instance
  logic            start_s = 1'b0;
  logic [SR*SC-1:0] bitmap_s = '0;
  logic            busy_s, done_s, empty_s;
  logic [2:0]      top_s, bottom_s;
  logic [3:0]      left_s, right_s;
  logic [5:0]      pix_s;

  bmp_trim_scan dut (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bitmap(bitmap_b),
    .busy(busy_b), .done(done_b), .top_pad(top_b), .bottom_pad(bottom_b),
    .left_pad(left_b), .right_pad(right_b), .empty(empty_b), .pix_count(pix_b)
  );

  bmp_trim_scan #(.COLS(SC), .ROWS(SR)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .bitmap(bitmap_s),
    .busy(busy_s), .done(done_s), .top_pad(top_s), .bottom_pad(bottom_s),
    .left_pad(left_s), .right_pad(right_s), .empty(empty_s), .pix_count(pix_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the picture row by row, from the bitmap's own layout rules.
  function automatic res_t model(input logic [NB-1:0] bm, input int rows, input int cols);
    res_t r;
    logic [63:0] orv;
    int first, last, pix;
    bit any;
    orv = '0; first = -1; last = -1; pix = 0;
    for (int y = 0; y < rows; y++) begin
      any = 1'b0;
      for (int x = 0; x < cols; x++) begin
        if (bm[(rows - y) * cols - 1 - x]) begin
          any = 1'b1;
          orv[x] = 1'b1;
          pix++;
        end
      end
      if (any) begin
        if (first < 0) first = y;
        last = y;
      end
    end
    if (first < 0) begin
      r.top = rows; r.bottom = rows; r.left = cols; r.right = cols; r.empty = 1;
    end else begin
      r.top = first;
      r.bottom = rows - 1 - last;
      r.empty = 0;
      r.left = 0;
      while (!orv[r.left]) r.left++;
      r.right = 0;
      while (!orv[cols - 1 - r.right]) r.right++;
    end
    r.pix = (POPCNT_ON != 0) ? pix : 0;
    return r;
  endfunction

  function automatic res_t zero_res();
    res_t r;
    r.top = 0; r.bottom = 0; r.left = 0; r.right = 0; r.empty = 0; r.pix = 0;
    return r;
  endfunction

  function automatic logic [NB-1:0] rand_bitmap();
    logic [NB-1:0]   bm;
    logic [COLS-1:0] mask;
    int lo, hi, t0, b0;
    bm = '0;
    if ($urandom_range(0, 5) == 0) return bm;
    lo = int'($urandom_range(0, COLS - 1));
    hi = int'($urandom_range(lo, COLS - 1));
    mask = '0;
    for (int c = lo; c <= hi; c++) mask[c] = 1'b1;
    t0 = int'($urandom_range(0, 20));
    b0 = int'($urandom_range(0, 20));
    for (int r = 0; r < ROWS; r++) begin
      if (r >= t0 && r < ROWS - b0 && $urandom_range(0, 2) != 0)
        bm[(ROWS - r) * COLS - 1 -: COLS] = COLS'($urandom) & mask;
    end
    return bm;
  endfunction

  // Cycle-level expectation for the default instance: a scan occupies ROWS+1 edges.
  int   m_rem = 0;
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  res_t m_res, m_snap;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
      m_res = zero_res(); m_snap = zero_res();
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
          m_res  = m_snap;
        end
      end else if (start_b) begin
        m_snap = model(bitmap_b, ROWS, COLS);
        m_rem  = ROWS + 1;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy_b), int'(m_busy));
      check("done", int'(done_b), int'(m_done));
      check("top_pad", int'(top_b), m_res.top);
      check("bottom_pad", int'(bottom_b), m_res.bottom);
      check("left_pad", int'(left_b), m_res.left);
      check("right_pad", int'(right_b), m_res.right);
      check("empty", int'(empty_b), m_res.empty);
      check("pix_count", int'(pix_b), m_res.pix);
      if (done_b) done_cnt++;
    end
  end

  task automatic start_big(input logic [NB-1:0] bm);
    bitmap_b = bm;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
  endtask

  task automatic wait_done_big(input int lat0, output int lat);
    lat = lat0;
    while (!done_b && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_big(input string tag, input int t, input int b, input int l,
                           input int r, input int e, input int p);
    check({tag, "_top"}, int'(top_b), t);
    check({tag, "_bottom"}, int'(bottom_b), b);
    check({tag, "_left"}, int'(left_b), l);
    check({tag, "_right"}, int'(right_b), r);
    check({tag, "_empty"}, int'(empty_b), e);
    check({tag, "_pix"}, int'(pix_b), p);
  endtask

  task automatic small_scan(input logic [SR*SC-1:0] bm);
    res_t exp;
    int lat;
    bitmap_s = bm;
    start_s  = 1'b1;
    @(negedge clk);
    start_s  = 1'b0;
    lat = 0;
    while (!done_s && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    exp = model({{(NB - SR*SC){1'b0}}, bm}, SR, SC);
    check("s_latency", lat, SR + 1);
    check("s_busy_at_done", int'(busy_s), 0);
    check("s_top", int'(top_s), exp.top);
    check("s_bottom", int'(bottom_s), exp.bottom);
    check("s_left", int'(left_s), exp.left);
    check("s_right", int'(right_s), exp.right);
    check("s_empty", int'(empty_s), exp.empty);
    check("s_pix", int'(pix_s), exp.pix);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, want < 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] ref_bm, bm;
    int lat, cnt0;

    ref_bm = '0;
    for (int r = 0; r < ROWS; r++)
      if ((r >= 3 && r <= 4) || (r >= 7 && r <= 61)) ref_bm[(ROWS - r) * COLS - 1 -: COLS] = 24'h3FFFFF;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", int'(busy_b), 0);
    check("reset_done", int'(done_b), 0);
    check_big("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference pattern
    start_big(ref_bm);
    wait_done_big(0, lat);
    check("ref_latency", lat, 65);
    check("ref_busy_at_done", int'(busy_b), 0);
    check_big("ref", 3, 2, 2, 0, 0, POPCNT_ON * 1254);
    @(negedge clk);

    // All-zero bitmap
    start_big('0);
    wait_done_big(0, lat);
    check("zero_latency", lat, 65);
    check_big("zero", 64, 64, 24, 24, 1, 0);
    @(negedge clk);

    // Re-pulsed start and bitmap rewrite mid-scan are ignored
    start_big(ref_bm);
    cnt0 = done_cnt;
    repeat (19) @(negedge clk);
    bitmap_b = '1;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
    wait_done_big(20, lat);
    check("repulse_latency", lat, 65);
    check_big("repulse", 3, 2, 2, 0, 0, POPCNT_ON * 1254);
    repeat (5) @(negedge clk);
    check("repulse_one_done", done_cnt - cnt0, 1);

    // Reset in the middle of a scan aborts it
    start_big('1);
    cnt0 = done_cnt;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", int'(busy_b), 0);
    check_big("abort", 0, 0, 0, 0, 0, 0);
    repeat (70) @(negedge clk);
    check("abort_no_done", done_cnt - cnt0, 0);

    // Single pixel at row 10, bit 5, following the abort
    bm = '0;
    bm[(ROWS - 1 - 10) * COLS + 5] = 1'b1;
    start_big(bm);
    wait_done_big(0, lat);
    check("pixel_latency", lat, 65);
    check_big("pixel", 10, 53, 18, 5, 0, POPCNT_ON);

    // Random back-to-back scans with ignored restarts and bitmap churn while busy
    for (int it = 0; it < 16; it++) begin
      bitmap_b = rand_bitmap();
      start_b  = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      lat = 0;
      while (!done_b && lat < 200) begin
        if ($urandom_range(0, 7) == 0) begin
          start_b  = 1'b1;
          bitmap_b = rand_bitmap();
        end else begin
          start_b = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
      start_b = 1'b0;
      check("rand_latency", lat, 65);
    end
    @(negedge clk);

    // Small geometry
    small_scan('1);
    check("s_ones_top", int'(top_s), 0);
    check("s_ones_left", int'(left_s), 0);
    check("s_ones_pix", int'(pix_s), POPCNT_ON * 32);
    @(negedge clk);
    small_scan('0);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      small_scan(32'($urandom) & 32'($urandom));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
